// File: rtl/f_fetch_stage.sv
// Fetch stage of the P7 MIPS pipeline: owns the PC, selects next-PC and flags AdEL faults.
// Optional FETCH_CNT_EN adds a free-running count of enabled, non-exception fetch edges.
module f_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_PC   = 32'h0000_4180,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter logic [31:0] IM_TOP   = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        req,
   input  logic        eret_d,
   input  logic [31:0] epc,
   input  logic [1:0]  npc_sel,
   input  logic [31:0] b_target,
   input  logic [31:0] j_target,
   input  logic [31:0] r_target,
   input  logic        d_is_jmp,
   input  logic [31:0] instr_i,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic [4:0]  exc_o,
   output logic        bd_o
`ifdef FETCH_CNT_EN
   ,
   output logic [31:0] fetch_cnt
`endif
);

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        fault;
   logic        eret_squash;

   always_comb begin
      pc_next = pc;
      if (req) begin
         pc_next = EXC_PC;
      end else if (en && eret_d) begin
         pc_next = epc;
      end else if (en) begin
         unique case (npc_sel)
            2'd0:    pc_next = pc + 32'd4;
            2'd1:    pc_next = b_target;
            2'd2:    pc_next = j_target;
            default: pc_next = r_target;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

   // eret has no delay slot, so the word fetched alongside it is replaced by a nop.
   assign eret_squash = eret_d & en;
   assign fault       = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_TOP);

   always_comb begin
      instr_o = instr_i;
      exc_o   = EXC_NONE;
      bd_o    = d_is_jmp;
      if (eret_squash) begin
         instr_o = 32'd0;
         bd_o    = 1'b0;
      end else if (fault) begin
         instr_o = 32'd0;
         exc_o   = EXC_ADEL;
      end
   end

   assign pc_o = pc;

`ifdef FETCH_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt <= 32'd0;
      end else if (en && !req) begin
         fetch_cnt <= fetch_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_f_fetch_stage.sv
// Bench for f_fetch_stage: directed test-plan sequences plus randomized traffic against a PC model.
module tb_f_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset, en, req, eret_d, d_is_jmp;
  logic [31:0] epc, b_target, j_target, r_target, instr_i;
  logic [1:0]  npc_sel;
  logic [31:0] pc_o, instr_o;
  logic [4:0]  exc_o;
  logic        bd_o;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  // clock/reset block
  always #5 clk = ~clk;

  f_fetch_stage dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .req      (req),
    .eret_d   (eret_d),
    .epc      (epc),
    .npc_sel  (npc_sel),
    .b_target (b_target),
    .j_target (j_target),
    .r_target (r_target),
    .d_is_jmp (d_is_jmp),
    .instr_i  (instr_i),
    .pc_o     (pc_o),
    .instr_o  (instr_o),
    .exc_o    (exc_o),
    .bd_o     (bd_o)
`ifdef FETCH_CNT_EN
    ,
    .fetch_cnt(fetch_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_addr(input logic [31:0] a);
    return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6FFC);
  endfunction

  // driver: one clock of stimulus, checks outputs mid-cycle, then advances the model
  task automatic step(input logic r, input logic e, input logic q, input logic er,
                      input logic [31:0] ep, input logic [1:0] sel, input logic [31:0] b,
                      input logic [31:0] j, input logic [31:0] rt, input logic jmp,
                      input logic [31:0] ins);
    logic squash;
    @(negedge clk);
    reset = r; en = e; req = q; eret_d = er; epc = ep; npc_sel = sel;
    b_target = b; j_target = j; r_target = rt; d_is_jmp = jmp; instr_i = ins;
    #1;
    squash = er && e;
    check("pc", pc_o, m_pc);
    check("instr", instr_o, (squash || !legal_addr(m_pc)) ? 32'd0 : ins);
    check("exc", {27'd0, exc_o}, (!squash && !legal_addr(m_pc)) ? 32'd4 : 32'd0);
    check("bd", {31'd0, bd_o}, squash ? 32'd0 : {31'd0, jmp});
`ifdef FETCH_CNT_EN
    check("cnt", fetch_cnt, m_cnt);
`endif
    if (r)            m_pc = RESET_PC;
    else if (q)       m_pc = EXC_PC;
    else if (e && er) m_pc = ep;
    else if (e) begin
      case (sel)
        2'd0: m_pc = m_pc + 32'd4;
        2'd1: m_pc = b;
        2'd2: m_pc = j;
        default: m_pc = rt;
      endcase
    end
    if (r) m_cnt = 32'd0;
    else if (e && !q) m_cnt = m_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input logic [31:0] ins);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0, ins);
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
  endfunction

  initial begin
    reset = 1'b1; en = 1'b0; req = 1'b0; eret_d = 1'b0; epc = '0; npc_sel = '0;
    b_target = '0; j_target = '0; r_target = '0; d_is_jmp = 1'b0; instr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = RESET_PC;
    m_cnt = 32'd0;
    check("reset_pc", pc_o, 32'h3000);
    check("reset_exc", {27'd0, exc_o}, 32'd0);

    // sequential fetch
    repeat (3) seq($urandom);
    check("seq_pc", pc_o, 32'h300C);
    seq($urandom);
    // taken branch then delay-slot flag
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 2'd1, 32'h3100, 32'd0, 32'd0, 1'b0, $urandom);
    check("br_pc", pc_o, 32'h3100);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1, $urandom);
    // stall with a pending jump, then release
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 2'd3, 32'd0, 32'd0, 32'h3020, 1'b0, $urandom);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd2, 32'd0, 32'h3400, 32'd0, 1'b1, $urandom);
    check("stall_pc", pc_o, 32'h3020);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 2'd2, 32'd0, 32'h3400, 32'd0, 1'b1, $urandom);
    check("jump_pc", pc_o, 32'h3400);
    // misaligned jr faults, then exception entry
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 2'd3, 32'd0, 32'd0, 32'h3003, 1'b0, $urandom);
    check("adel_exc", {27'd0, exc_o}, 32'd4);
    check("adel_instr", instr_o, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0, $urandom);
    check("exc_pc", pc_o, 32'h4180);
    repeat (4) seq($urandom);
    check("handler_pc", pc_o, 32'h4190);
    // eret squash, then eret colliding with req
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h3208, 2'd1, 32'h5000, 32'd0, 32'd0, 1'b1, $urandom);
    check("eret_pc", pc_o, 32'h3208);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h3208, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0, $urandom);
    check("eret_req_pc", pc_o, 32'h4180);
    // PC+4 wraps past the top of the address space
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 2'd3, 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b0, $urandom);
    seq($urandom);
    check("wrap_pc", pc_o, 32'd0);
    seq($urandom);
    // reset during a stall with a redirect pending
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h5555, 2'd2, 32'd0, 32'h6000, 32'd0, 1'b1, $urandom);
    check("rst_mid_pc", pc_o, 32'h3000);

`ifdef FETCH_CNT_EN
    repeat (10) seq($urandom);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0, $urandom);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0, $urandom);
    check("cnt_ten", fetch_cnt, 32'd10);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0, $urandom);
    check("cnt_reset", fetch_cnt, 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) == 0, rand_target(), 2'($urandom_range(0, 3)), rand_target(),
           rand_target(), rand_target(), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/f_fetch_stage.md
Name: f_fetch_stage

Overview:
- Fetch stage of the P7 five-stage MIPS pipeline.
- Owns the program counter and computes next-PC from decode-stage redirects, exception requests and eret.
- Presents PC, instruction word, fetch exception code and branch-delay flag to the IF/ID pipeline register.
- Instruction memory is external and combinational: pc_o drives its address, and its data returns on instr_i in the same cycle.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_PC, 32'h0000_4180, exception/interrupt handler entry.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_TOP, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = stall, PC held.
- req  in  1  exception/interrupt taken this cycle (from CP0).
- eret_d  in  1  eret instruction currently in D.
- epc  in  32  return address from CP0.
- npc_sel  in  2  0=PC+4, 1=branch taken, 2=j/jal, 3=jr/jalr.
- b_target  in  32  branch target from D.
- j_target  in  32  j/jal target from D.
- r_target  in  32  register target from D.
- d_is_jmp  in  1  instruction in D is a branch or jump.
- instr_i  in  32  word from instruction memory at pc_o.
- pc_o  out  32  current fetch PC (registered).
- instr_o  out  32  instruction to IF/ID register.
- exc_o  out  5  fetch exception code: 0 = none, 4 = AdEL.
- bd_o  out  1  fetched instruction sits in a delay slot.

Behaviour:
- PC register update priority, highest first:
  - reset: PC <= RESET_PC.
  - req: PC <= EXC_PC. Applies regardless of en.
  - en & eret_d: PC <= epc.
  - en: PC <= per npc_sel:
    - 0: PC+4.
    - 1: b_target.
    - 2: j_target.
    - 3: r_target.
  - otherwise: PC held.
- PC+4 uses modulo-2^32 wrap (32'hFFFF_FFFC + 4 = 0). The illegal address is then caught by the AdEL check.
- Redirects take effect one cycle later; the instruction fetched in the redirect cycle is the delay slot and is not squashed.
- eret has no delay slot. While eret_d & en, instr_o = 0 (nop), exc_o = 0, bd_o = 0.
- AdEL check is combinational on pc_o. Fault when pc_o[1:0] != 0, or pc_o < IM_BASE, or pc_o > IM_TOP. On fault:
  - exc_o = 4 and instr_o = 0.
  - bd_o still reflects d_is_jmp, so CP0 computes EPC = PC-4 correctly.
- No fault: instr_o = instr_i, exc_o = 0.
- bd_o = d_is_jmp, except forced 0 during eret squash.
- Outputs after reset, before the first clock edge with en:
  - pc_o = RESET_PC.
  - exc_o = 0 (RESET_PC is legal).
  - bd_o = d_is_jmp.
- Stall (en=0): pc_o is stable and instr_o/exc_o track the held PC. npc_sel and target inputs are ignored.
- req and eret_d in the same cycle: req wins; PC <= EXC_PC.
- reset mid-stall or mid-redirect: reset wins and discards all pending inputs.

Optional Feature:
- Macro FETCH_CNT_EN.
- Defined:
  - Adds output fetch_cnt, 32 bits, reset to 0.
  - Increments by 1 on each clock edge where en=1, req=0 and reset=0; wraps at 2^32.
  - A req edge does not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then en=1, npc_sel=0 for 3 cycles -> pc_o = 3000, 3004, 3008, 300C; exc_o = 0 throughout.
- At pc_o=3010, npc_sel=1, b_target=3100, d_is_jmp=0 -> next pc_o = 3100. Then with d_is_jmp=1 at 3100 -> bd_o = 1.
- en=0 for 4 cycles at pc_o=3020 with npc_sel=2, j_target=3400 -> pc_o stays 3020. After en returns to 1 -> pc_o = 3400.
- r_target=3003 via npc_sel=3 -> pc_o = 3003, exc_o = 4, instr_o = 0. Then req=1 -> pc_o = 4180, exc_o = 0.
- eret_d=1, epc=3208, en=1 at pc_o=4190 -> instr_o = 0 and bd_o = 0 that cycle; next pc_o = 3208. Repeating with req=1 in the same cycle -> next pc_o = 4180.
- With FETCH_CNT_EN: 10 enabled cycles, 3 stalled cycles, 1 req cycle -> fetch_cnt = 10. reset -> fetch_cnt = 0.
